// File: rtl/frame_tx_2m4.sv
// frame_tx_2m4 -- serial frame transmitter for the optical link.
//
// Accepts a parallel word over a valid/ready handshake and shifts it out one
// bit per bit tick, MSB first, framed as: SYNC word, DATA, optional even
// parity bit, STOP bits (all ones). A bit tick is the first Clk_24M cycle in
// which the divider output Clk_2M4 is seen high after being low.
//
// Optional feature: define FRAME_PARITY_EN to append one even-parity bit
// (XOR of the DATA bits) between DATA and STOP.
//
// Ports:
//   Clk_24M     in   1       system clock
//   Rst_n       in   1       synchronous active-low reset
//   Clk_2M4     in   1       bit clock from divider, synchronous to Clk_24M
//   Data_in     in   DATA_W  payload word, sampled only at the handshake
//   Data_valid  in   1       Data_in valid
//   Data_ready  out  1       transmitter can accept a word (registered)
//   Tx_out      out  1       serial line, idle level 1 (registered)
//   Tx_busy     out  1       frame in progress, i.e. state != IDLE (registered)
//   Frame_done  out  1       one-cycle pulse as the last stop bit period ends
module frame_tx_2m4 #(
  parameter int                DATA_W    = 16,
  parameter int                SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA5,
  parameter int                STOP_BITS = 2
) (
  input  logic              Clk_24M,
  input  logic              Rst_n,
  input  logic              Clk_2M4,
  input  logic [DATA_W-1:0] Data_in,
  input  logic              Data_valid,
  output logic              Data_ready,
  output logic              Tx_out,
  output logic              Tx_busy,
  output logic              Frame_done
);

  // The counter holds "bits already sent in this field", so it must reach the
  // largest field length without wrapping.
  localparam int MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int MAX_FLD = (MAX_SD > STOP_BITS) ? MAX_SD : STOP_BITS;
  localparam int CNT_W   = $clog2(MAX_FLD + 1);
  localparam int FR_W    = SYNC_W + DATA_W;

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_SYNC,
    S_DATA,
`ifdef FRAME_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_t;

  state_t            state;
  logic              c_d;
  logic              tick;
  // SYNC and DATA share one shift register: the line always takes the MSB,
  // the counter only tracks where the field boundaries fall.
  logic [FR_W-1:0]   frame_sr;
  logic [CNT_W-1:0]  cnt;

`ifdef FRAME_PARITY_EN
  logic              par_q;

  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  // Edge detect on the divider output; c_d clears on reset so a high
  // Clk_2M4 right after reset still counts as a tick.
  always_ff @(posedge Clk_24M) begin
    if (!Rst_n) c_d <= 1'b0;
    else        c_d <= Clk_2M4;
  end

  assign tick = Clk_2M4 & ~c_d;

  always_ff @(posedge Clk_24M) begin
    if (!Rst_n) begin
      state      <= S_IDLE;
      Tx_out     <= 1'b1;
      Data_ready <= 1'b0;
      Tx_busy    <= 1'b0;
      Frame_done <= 1'b0;
      frame_sr   <= '0;
      cnt        <= '0;
`ifdef FRAME_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      Frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Data_valid && Data_ready) begin
            frame_sr   <= {SYNC_WORD, Data_in};
`ifdef FRAME_PARITY_EN
            par_q      <= even_par(Data_in);
`endif
            cnt        <= '0;
            state      <= S_ARMED;
            Data_ready <= 1'b0;
            Tx_busy    <= 1'b1;
          end else begin
            Data_ready <= 1'b1;
          end
        end
        S_ARMED: begin
          if (tick) begin
            Tx_out   <= frame_sr[FR_W-1];
            frame_sr <= frame_sr << 1;
            cnt      <= CNT_ONE;
            state    <= S_SYNC;
          end
        end
        S_SYNC: begin
          // The tick that ends the last sync bit already sends DATA's MSB.
          if (tick) begin
            Tx_out   <= frame_sr[FR_W-1];
            frame_sr <= frame_sr << 1;
            if (cnt == SYNC_LAST) begin
              cnt   <= CNT_ONE;
              state <= S_DATA;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (cnt == DATA_LAST) begin
`ifdef FRAME_PARITY_EN
              Tx_out <= par_q;
              state  <= S_PAR;
`else
              Tx_out <= 1'b1;
              cnt    <= CNT_ONE;
              state  <= S_STOP;
`endif
            end else begin
              Tx_out   <= frame_sr[FR_W-1];
              frame_sr <= frame_sr << 1;
              cnt      <= cnt + CNT_ONE;
            end
          end
        end
`ifdef FRAME_PARITY_EN
        S_PAR: begin
          if (tick) begin
            Tx_out <= 1'b1;
            cnt    <= CNT_ONE;
            state  <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          // The line stays high through the end of the frame; the tick
          // after the last stop bit is the inter-frame idle bit's start.
          if (tick) begin
            Tx_out <= 1'b1;
            if (cnt == STOP_LAST) begin
              state      <= S_IDLE;
              Frame_done <= 1'b1;
              Tx_busy    <= 1'b0;
              Data_ready <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        default: begin
          state      <= S_IDLE;
          Tx_out     <= 1'b1;
          Tx_busy    <= 1'b0;
          Data_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_tx_2m4.sv
// tb_frame_tx_2m4 -- directed self-checking bench for frame_tx_2m4.
// Clk_2M4 is produced as Clk_24M/10 (5 high, 5 low) and can be held low.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_frame_tx_2m4;

`ifdef FRAME_PARITY_EN
  localparam int FLEN = 27;
  localparam logic [31:0] F_1234 = 32'b00000_10100101_0001001000110100_1_11;
`else
  localparam int FLEN = 26;
  localparam logic [31:0] F_1234 = 32'b000000_10100101_0001001000110100_11;
`endif

  logic        Clk_24M;
  logic        Rst_n;
  logic        Clk_2M4;
  logic [15:0] Data_in;
  logic        Data_valid;
  logic        Data_ready;
  logic        Tx_out;
  logic        Tx_busy;
  logic        Frame_done;

  logic        en_2m4;
  int          checks;
  int          failures;
  int          done_cnt;

  frame_tx_2m4 dut (
    .Clk_24M   (Clk_24M),
    .Rst_n     (Rst_n),
    .Clk_2M4   (Clk_2M4),
    .Data_in   (Data_in),
    .Data_valid(Data_valid),
    .Data_ready(Data_ready),
    .Tx_out    (Tx_out),
    .Tx_busy   (Tx_busy),
    .Frame_done(Frame_done)
  );

  initial Clk_24M = 1'b0;
  always #5 Clk_24M = ~Clk_24M;

  // Divider model: changes 1 ns after the rising edge, restarts high on enable.
  initial begin
    int div;
    Clk_2M4 = 1'b0;
    div = 0;
    forever begin
      @(posedge Clk_24M);
      #1;
      if (!en_2m4) begin
        Clk_2M4 = 1'b0;
        div = 0;
      end else begin
        Clk_2M4 = (div < 5);
        div = (div == 9) ? 0 : div + 1;
      end
    end
  end

  initial done_cnt = 0;
  always @(negedge Clk_24M) if (Frame_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected frame, first bit sent in bit FLEN-1.
  function automatic logic [31:0] mk_frame(input logic [15:0] d);
`ifdef FRAME_PARITY_EN
    return {5'b0, 8'hA5, d, ^d, 2'b11};
`else
    return {6'b0, 8'hA5, d, 2'b11};
`endif
  endfunction

  // Returns one cycle after the accepting edge; p is Clk_2M4 as seen just
  // before that edge, so only later rises are taken as frame-start ticks.
  task automatic handshake(input logic [15:0] d, input bit keep, output logic p);
    int i;
    Data_in = d;
    Data_valid = 1'b1;
    i = 0;
    while (Data_ready !== 1'b1 && i < 60) begin
      @(negedge Clk_24M);
      i++;
    end
    if (Data_ready !== 1'b1) chk("hs_timeout", 32'd0, 32'd1);
    p = Clk_2M4;
    @(negedge Clk_24M);
    if (!keep) Data_valid = 1'b0;
  endtask

  // Waits for the next Clk_2M4 rise, then moves to the middle of that bit.
  task automatic find_first(input logic p_in);
    logic p;
    bit   found;
    p = p_in;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (Clk_2M4 && !p) found = 1'b1;
      else begin
        p = Clk_2M4;
        @(negedge Clk_24M);
      end
    end
    if (!found) chk("tick_timeout", 32'd0, 32'd1);
    repeat (4) @(negedge Clk_24M);
  endtask

  // Starts mid first bit; ends mid last bit.
  task automatic check_bits(input string tag, input logic [31:0] f, output logic [31:0] obs);
    obs = '0;
    chk({tag, "_busy"}, Tx_busy, 1'b1);
    for (int i = 0; i < FLEN; i++) begin
      obs[FLEN-1-i] = Tx_out;
      if (Tx_out !== f[FLEN-1-i]) chk($sformatf("%s_bit%0d", tag, i), Tx_out, f[FLEN-1-i]);
      if (i < FLEN - 1) repeat (10) @(negedge Clk_24M);
    end
    chk({tag, "_frame"}, obs, f);
  endtask

  // From mid last stop bit: Frame_done in the cycle after the ending tick,
  // then mid of the following idle bit.
  task automatic end_checks(input string tag);
    repeat (7) @(negedge Clk_24M);
    chk({tag, "_done"}, Frame_done, 1'b1);
    chk({tag, "_busy_end"}, Tx_busy, 1'b0);
    @(negedge Clk_24M);
    chk({tag, "_done_1cyc"}, Frame_done, 1'b0);
    repeat (2) @(negedge Clk_24M);
    chk({tag, "_idle_tx"}, Tx_out, 1'b1);
  endtask

  initial begin
    logic        p;
    logic [31:0] obs;
    int          d0;
    checks = 0;
    failures = 0;
    en_2m4 = 1'b1;
    Rst_n = 1'b0;
    Data_valid = 1'b0;
    Data_in = '0;

    // Reset and idle
    repeat (3) @(negedge Clk_24M);
    chk("rst_tx", Tx_out, 1'b1);
    chk("rst_ready", Data_ready, 1'b0);
    chk("rst_busy", Tx_busy, 1'b0);
    chk("rst_done", Frame_done, 1'b0);
    Rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk_24M);
      chk("idle_tx", Tx_out, 1'b1);
      chk("idle_ready", Data_ready, 1'b1);
      chk("idle_busy", Tx_busy, 1'b0);
    end

    // Single frame 0x1234
    d0 = done_cnt;
    handshake(16'h1234, 1'b0, p);
    chk("hs_ready_low", Data_ready, 1'b0);
    find_first(p);
    check_bits("f1234", F_1234, obs);
    end_checks("f1234");
    chk("f1234_ready", Data_ready, 1'b1);
    chk("f1234_ndone", done_cnt - d0, 32'd1);

    // Back-to-back with valid held high, Data_in changed mid-frame
    d0 = done_cnt;
    handshake(16'h00FF, 1'b1, p);
    Data_in = 16'hFF00;
    find_first(p);
    check_bits("b2b_a", mk_frame(16'h00FF), obs);
    end_checks("b2b_a");
    chk("b2b_armed_busy", Tx_busy, 1'b1);
    chk("b2b_armed_ready", Data_ready, 1'b0);
    Data_valid = 1'b0;
    repeat (10) @(negedge Clk_24M);
    check_bits("b2b_b", mk_frame(16'hFF00), obs);
    end_checks("b2b_b");
    chk("b2b_ready", Data_ready, 1'b1);
    chk("b2b_ndone", done_cnt - d0, 32'd2);

    // Divider stuck low after handshake
    @(negedge Clk_24M);
    en_2m4 = 1'b0;
    repeat (3) @(negedge Clk_24M);
    handshake(16'hBEEF, 1'b0, p);
    for (int i = 0; i < 500; i++) begin
      chk("stuck_tx", Tx_out, 1'b1);
      chk("stuck_busy", Tx_busy, 1'b1);
      chk("stuck_ready", Data_ready, 1'b0);
      @(negedge Clk_24M);
    end
    en_2m4 = 1'b1;
    find_first(1'b0);
    check_bits("stuck", mk_frame(16'hBEEF), obs);
    end_checks("stuck");

    // Reset in the middle of DATA
    repeat (20) @(negedge Clk_24M);
    handshake(16'h0000, 1'b0, p);
    find_first(p);
    repeat (110) @(negedge Clk_24M);
    chk("mid_data_tx", Tx_out, 1'b0);
    chk("mid_data_busy", Tx_busy, 1'b1);
    d0 = done_cnt;
    Rst_n = 1'b0;
    @(negedge Clk_24M);
    chk("abort_tx", Tx_out, 1'b1);
    chk("abort_busy", Tx_busy, 1'b0);
    chk("abort_done", Frame_done, 1'b0);
    Rst_n = 1'b1;
    repeat (300) @(negedge Clk_24M);
    chk("abort_ndone", done_cnt - d0, 32'd0);
    chk("abort_idle_tx", Tx_out, 1'b1);
    chk("abort_idle_ready", Data_ready, 1'b1);
    handshake(16'h5A3C, 1'b0, p);
    find_first(p);
    check_bits("after_rst", mk_frame(16'h5A3C), obs);
    end_checks("after_rst");

    // Parity cases (frames still checked without the parity option)
    handshake(16'h0001, 1'b0, p);
    find_first(p);
    check_bits("f0001", mk_frame(16'h0001), obs);
`ifdef FRAME_PARITY_EN
    chk("par_0001", obs[2], 1'b1);
`endif
    end_checks("f0001");
    handshake(16'h0003, 1'b0, p);
    find_first(p);
    check_bits("f0003", mk_frame(16'h0003), obs);
`ifdef FRAME_PARITY_EN
    chk("par_0003", obs[2], 1'b0);
`endif
    end_checks("f0003");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
